// File: rtl/shifter8_iter.sv
// shifter8_iter: multi-cycle 8-bit shift unit.
//
// A single mux-based shift stage moves the accumulator by 0..3 positions per
// pass. The unit iterates that stage until the requested 3-bit amount has been
// consumed, then publishes the result on d_out with a one-cycle done pulse.
//
// Ports:
//   clk    in   system clock, rising-edge active
//   reset  in   synchronous, active-high reset
//   start  in   request, sampled only while busy=0
//   op     in   2'b00 LSL, 2'b01 LSR, 2'b10 ASR, 2'b11 ROR
//   d_in   in   8-bit operand, sampled with start
//   shamt  in   total shift amount 0..7, sampled with start
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle pulse when d_out carries a new result
//   d_out  out  registered result, held until the next completion
module shifter8_iter (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] d_in,
  input  logic [2:0] shamt,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [1:0] OpLsl = 2'b00;
  localparam logic [1:0] OpLsr = 2'b01;
  localparam logic [1:0] OpAsr = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] rem_q, rem_d;
  logic [1:0] op_q, op_d;
  logic [7:0] d_out_q, d_out_d;

  logic [1:0] step;
  logic [2:0] rem_next;
  logic [7:0] stage1;
  logic [7:0] stage_out;

  // Per-pass step is the remaining amount clamped to the stage maximum of 3.
  always_comb begin
    step     = (rem_q > 3'd3) ? 2'd3 : rem_q[1:0];
    rem_next = rem_q - {1'b0, step};
  end

  // Two-level shift stage: level 1 moves by step[0], level 2 by 2*step[1].
  // For ASR, level 1 preserves bit 7, so level 2 still sees the original sign.
  always_comb begin
    stage1 = acc_q;
    if (step[0]) begin
      unique case (op_q)
        OpLsl:   stage1 = {acc_q[6:0], 1'b0};
        OpLsr:   stage1 = {1'b0, acc_q[7:1]};
        OpAsr:   stage1 = {acc_q[7], acc_q[7:1]};
        OpRor:   stage1 = {acc_q[0], acc_q[7:1]};
        default: stage1 = acc_q;
      endcase
    end

    stage_out = stage1;
    if (step[1]) begin
      unique case (op_q)
        OpLsl:   stage_out = {stage1[5:0], 2'b00};
        OpLsr:   stage_out = {2'b00, stage1[7:2]};
        OpAsr:   stage_out = {{2{stage1[7]}}, stage1[7:2]};
        OpRor:   stage_out = {stage1[1:0], stage1[7:2]};
        default: stage_out = stage1;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    d_out_d = d_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = d_in;
          rem_d   = shamt;
          op_d    = op;
          state_d = StShift;
        end
      end
      StShift: begin
        // A zero amount still takes one pass with step 0.
        acc_d = stage_out;
        rem_d = rem_next;
        if (rem_next == 3'd0) begin
          d_out_d = stage_out;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= 8'h00;
      rem_q   <= 3'd0;
      op_q    <= 2'b00;
      d_out_q <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      d_out_q <= d_out_d;
    end
  end

  always_comb begin
    busy  = (state_q == StShift) || (state_q == StDone);
    done  = (state_q == StDone);
    d_out = d_out_q;
  end

endmodule

// File: tb/tb_shifter8_iter.sv
module tb_shifter8_iter;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  int n_checks;
  int n_fail;

  shifter8_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .d_in  (d_in),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] din;
    logic [2:0] sh;
    logic [7:0] exp;
    int         n;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request at the next falling edge; returns after the acceptance edge,
  // positioned on the following falling edge with start already dropped.
  task automatic issue(input logic [1:0] o, input logic [7:0] d, input logic [2:0] s);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    d_in  = d;
    shamt = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count SHIFT cycles until done, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 8) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(v.op, v.din, v.sh);
    check({tag, " busy_in_shift"}, 32'(busy), 32'd1);
    wait_done(cnt);
    check({tag, " shift_cycles"}, 32'(cnt), 32'(v.n));
    check({tag, " d_out"}, 32'(d_out), 32'(v.exp));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " done_width"}, 32'(done), 32'd0);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, " d_out_hold"}, 32'(d_out), 32'(v.exp));
  endtask

  initial begin
    int cnt;
    int n_done;
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    op       = 2'b00;
    d_in     = 8'h00;
    shamt    = 3'd0;

    vecs[0]  = '{2'b10, 8'h96, 3'd7, 8'hFF, 3};
    vecs[1]  = '{2'b10, 8'h96, 3'd5, 8'hFC, 2};
    vecs[2]  = '{2'b01, 8'h96, 3'd4, 8'h09, 2};
    vecs[3]  = '{2'b00, 8'h96, 3'd3, 8'hB0, 1};
    vecs[4]  = '{2'b11, 8'h96, 3'd5, 8'hB4, 2};
    vecs[5]  = '{2'b00, 8'h5A, 3'd0, 8'h5A, 1};
    vecs[6]  = '{2'b01, 8'h5A, 3'd0, 8'h5A, 1};
    vecs[7]  = '{2'b10, 8'h5A, 3'd0, 8'h5A, 1};
    vecs[8]  = '{2'b11, 8'h5A, 3'd0, 8'h5A, 1};
    vecs[9]  = '{2'b01, 8'h96, 3'd7, 8'h01, 3};
    vecs[10] = '{2'b11, 8'h96, 3'd7, 8'h2D, 3};
    vecs[11] = '{2'b00, 8'hFF, 3'd6, 8'hC0, 2};
    vecs[12] = '{2'b10, 8'h7F, 3'd6, 8'h01, 2};

    // Reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d_out", 32'(d_out), 32'h00);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Requests while busy (including during DONE) must be ignored.
    issue(2'b00, 8'h01, 3'd7);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n_done++;
      start = busy;
      d_in  = 8'hFF;
      op    = 2'b11;
      shamt = 3'd1;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_ignore d_out", 32'(d_out), 32'h80);
    check("busy_ignore done_count", 32'(n_done), 32'd1);
    check("busy_ignore idle", 32'(busy), 32'd0);

    // Reset during the second SHIFT cycle discards the operation.
    issue(2'b10, 8'h80, 3'd7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset d_out", 32'(d_out), 32'h00);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    check("midreset no_activity", 32'(n_done), 32'd0);

    issue(2'b10, 8'h80, 3'd7);
    wait_done(cnt);
    check("post_reset shift_cycles", 32'(cnt), 32'd3);
    check("post_reset d_out", 32'(d_out), 32'hFF);
    @(negedge clk);
    check("post_reset done_width", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
